// File: rtl/scc_register_decoder_if.sv
// Cartridge bus between the host CPU model and scc_register_decoder.
//
// Ports (signals):
//    bus_req   host -> decoder  request level, held until bus_ack
//    bus_wr    host -> decoder  1 write, 0 read (valid with bus_req)
//    bus_a     host -> decoder  16-bit CPU address
//    bus_d     host -> decoder  8-bit write data
//    bus_ready decoder -> host  decoder idle and able to sample a request
//    bus_ack   decoder -> host  transaction complete
//    bus_q     decoder -> host  read data (valid with bus_ack)
//    bus_q_en  decoder -> host  read hit (valid with bus_ack)
//
// Handshake: the host raises bus_req with bus_wr/bus_a/bus_d stable and holds
// all four until it sees bus_ack. The decoder samples a request only while
// bus_ready is high (IDLE) on an enable cycle. bus_ack stays high until the
// next enable cycle, so it is one event regardless of enable gaps. The host
// drops bus_req on the enable cycle it sees bus_ack; a request still held
// after that is treated as a new transaction.
interface scc_register_decoder_if;
   logic        bus_req;
   logic        bus_wr;
   logic [15:0] bus_a;
   logic [7:0]  bus_d;
   logic        bus_ready;
   logic        bus_ack;
   logic [7:0]  bus_q;
   logic        bus_q_en;

   modport master (
      output bus_req, bus_wr, bus_a, bus_d,
      input  bus_ready, bus_ack, bus_q, bus_q_en
   );

   modport slave (
      input  bus_req, bus_wr, bus_a, bus_d,
      output bus_ready, bus_ack, bus_q, bus_q_en
   );
endinterface

// File: rtl/scc_register_decoder.sv
// CPU-side front end of the SCC/SCC-I wave-table sound block.
// Decodes cartridge bus cycles into bank, mode, frequency, volume, enable and
// deformation registers, forwards wave-RAM accesses to the mixer over sram_*,
// and presents the per-slot channel registers selected by the mixer's slot.
//
// Ports:
//    clk, nreset          clock, synchronous active-low reset
//    enable               clock enable shared with the mixer
//    bus                  cartridge bus (slave side of scc_register_decoder_if)
//    sram_id/a/d          wave-RAM channel, address, write data (held)
//    sram_oe/sram_we      wave-RAM read/write strobe, high in ISSUE only
//    sram_q               wave-RAM read data from the mixer
//    active               mixer slot index
//    reg_scci_enable      SCC-I mode
//    reg_frequency_count  freq of channel 'active' (slots 0-4)
//    reg_volume/enable    vol/en of channel 'active-1' (slots 1-5)
//    reg_wave_reset       deformation bit 5
//    clear_counter_a..e   per-channel counter clear, one enable cycle
//    state_dbg            FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
module scc_register_decoder #(
   parameter bit scc_only = 1'b0
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 enable,
   scc_register_decoder_if.slave bus,
   output logic [2:0]           sram_id,
   output logic [4:0]           sram_a,
   output logic [7:0]           sram_d,
   output logic                 sram_oe,
   output logic                 sram_we,
   input  logic [7:0]           sram_q,
   input  logic [2:0]           active,
   output logic                 reg_scci_enable,
   output logic [11:0]          reg_frequency_count,
   output logic [3:0]           reg_volume,
   output logic                 reg_enable,
   output logic                 reg_wave_reset,
   output logic                 clear_counter_a,
   output logic                 clear_counter_b,
   output logic                 clear_counter_c,
   output logic                 clear_counter_d,
   output logic                 clear_counter_e,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;

   logic [7:0]  bank9_q;
   logic [7:0]  bankb_q;
   // Only bit 5 of the mode and deformation registers has any effect.
   logic        mode5_q;
   logic        deform5_q;
   logic [11:0] freq_q [5];
   logic [3:0]  vol_q [5];
   logic [4:0]  en_q;
   logic [4:0]  clr_q;
   logic        wr_q;
   logic [7:0]  bus_q_q;
   logic        bus_q_en_q;

   // Address decode
   logic [7:0]  o;
   logic [3:0]  r;
   logic [3:0]  vsel;
   logic        scc_win, scci_win;
   logic        dec_wave, dec_reg, dec_def;
   logic [2:0]  dec_id;
   logic        dec_bank9, dec_bankb, dec_mode;

   assign o               = bus.bus_a[7:0];
   assign r               = o[3:0];
   assign vsel            = r - 4'hA;
   assign reg_scci_enable = scc_only ? 1'b0 : mode5_q;
   assign reg_wave_reset  = deform5_q;

   always_comb begin
      dec_bank9 = (bus.bus_a[15:11] == 5'b10010);   // 9000-97FF
      dec_bankb = (bus.bus_a[15:11] == 5'b10110);   // B000-B7FF
      dec_mode  = (bus.bus_a[15:1]  == 15'h5FFF);   // BFFE/BFFF
      scc_win   = (bank9_q == 8'h3F) && !reg_scci_enable &&
                  (bus.bus_a[15:11] == 5'b10011);   // 9800-9FFF
      scci_win  = (bankb_q == 8'h80) && reg_scci_enable &&
                  (bus.bus_a[15:11] == 5'b10111);   // B800-BFFF
      dec_wave  = 1'b0;
      dec_reg   = 1'b0;
      dec_def   = 1'b0;
      dec_id    = 3'd0;
      if (scc_win) begin
         // Channels D and E share wave RAM in SCC mode, so only A-D are visible.
         dec_wave = (o[7] == 1'b0);
         dec_reg  = (o[7:5] == 3'b100);
         dec_def  = (o[7:5] == 3'b110);
         dec_id   = {1'b0, o[6:5]};
      end else if (scci_win) begin
         dec_wave = (o < 8'hA0);
         dec_reg  = (o[7:5] == 3'b101);
         dec_def  = (o[7:5] == 3'b110);
         dec_id   = o[7:5];
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= S_IDLE;
      end else if (enable) begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.bus_req) state_d = dec_wave ? S_ISSUE : S_DONE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.bus_ready = (state_q == S_IDLE);
      bus.bus_ack   = (state_q == S_DONE);
      sram_oe       = (state_q == S_ISSUE) && !wr_q;
      sram_we       = (state_q == S_ISSUE) && wr_q;
      state_dbg     = state_q;
   end

   assign bus.bus_q    = bus_q_q;
   assign bus.bus_q_en = bus_q_en_q;
   assign clear_counter_a = clr_q[0];
   assign clear_counter_b = clr_q[1];
   assign clear_counter_c = clr_q[2];
   assign clear_counter_d = clr_q[3];
   assign clear_counter_e = clr_q[4];

   // Registers and datapath
   always_ff @(posedge clk) begin
      if (!nreset) begin
         bank9_q    <= 8'h00;
         bankb_q    <= 8'h00;
         mode5_q    <= 1'b0;
         deform5_q  <= 1'b0;
         en_q       <= 5'd0;
         clr_q      <= 5'd0;
         wr_q       <= 1'b0;
         bus_q_q    <= 8'hFF;
         bus_q_en_q <= 1'b0;
         sram_id    <= 3'd0;
         sram_a     <= 5'd0;
         sram_d     <= 8'h00;
         for (int i = 0; i < 5; i++) begin
            freq_q[i] <= 12'd0;
            vol_q[i]  <= 4'd0;
         end
      end else if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (bus.bus_req) begin
                  wr_q       <= bus.bus_wr;
                  bus_q_q    <= 8'hFF;
                  bus_q_en_q <= !bus.bus_wr && (dec_wave || dec_reg || dec_def);
                  if (dec_wave) begin
                     sram_id <= dec_id;
                     sram_a  <= o[4:0];
                     sram_d  <= bus.bus_d;
                  end
                  if (bus.bus_wr) begin
                     if (dec_bank9) bank9_q <= bus.bus_d;
                     if (dec_bankb) bankb_q <= bus.bus_d;
                     if (dec_mode)  mode5_q <= bus.bus_d[5];
                     if (dec_def)   deform5_q <= bus.bus_d[5];
                     if (dec_reg) begin
                        if (r <= 4'd9) begin
                           if (r[0] == 1'b0) freq_q[r[3:1]][7:0]  <= bus.bus_d;
                           else              freq_q[r[3:1]][11:8] <= bus.bus_d[3:0];
                           // Pulse is presented during DONE, the next enable cycle.
                           clr_q[r[3:1]] <= 1'b1;
                        end else if (r <= 4'hE) begin
                           vol_q[vsel[2:0]] <= bus.bus_d[3:0];
                        end else begin
                           en_q <= bus.bus_d[4:0];
                        end
                     end
                  end
               end
            end
            S_WAIT: if (!wr_q) bus_q_q <= sram_q;
            S_DONE: clr_q <= 5'd0;
            default: ;
         endcase
      end
   end

   // Slot mux: frequency leads volume/enable by one slot.
   always_comb begin
      reg_frequency_count = 12'd0;
      reg_volume          = 4'd0;
      reg_enable          = 1'b0;
      case (active)
         3'd0: reg_frequency_count = freq_q[0];
         3'd1: reg_frequency_count = freq_q[1];
         3'd2: reg_frequency_count = freq_q[2];
         3'd3: reg_frequency_count = freq_q[3];
         3'd4: reg_frequency_count = freq_q[4];
         default: ;
      endcase
      case (active)
         3'd1: begin reg_volume = vol_q[0]; reg_enable = en_q[0]; end
         3'd2: begin reg_volume = vol_q[1]; reg_enable = en_q[1]; end
         3'd3: begin reg_volume = vol_q[2]; reg_enable = en_q[2]; end
         3'd4: begin reg_volume = vol_q[3]; reg_enable = en_q[3]; end
         3'd5: begin reg_volume = vol_q[4]; reg_enable = en_q[4]; end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_scc_register_decoder.sv
module tb_scc_register_decoder;

   logic        clk;
   logic        nreset;
   logic        enable;
   logic [2:0]  sram_id;
   logic [4:0]  sram_a;
   logic [7:0]  sram_d;
   logic        sram_oe;
   logic        sram_we;
   logic [7:0]  sram_q;
   logic [2:0]  active;
   logic        reg_scci_enable;
   logic [11:0] reg_frequency_count;
   logic [3:0]  reg_volume;
   logic        reg_enable;
   logic        reg_wave_reset;
   logic        clear_counter_a, clear_counter_b, clear_counter_c;
   logic        clear_counter_d, clear_counter_e;
   logic [1:0]  state_dbg;

   scc_register_decoder_if bus ();

   scc_register_decoder #(.scc_only(1'b0)) dut (
      .clk                 (clk),
      .nreset              (nreset),
      .enable              (enable),
      .bus                 (bus.slave),
      .sram_id             (sram_id),
      .sram_a              (sram_a),
      .sram_d              (sram_d),
      .sram_oe             (sram_oe),
      .sram_we             (sram_we),
      .sram_q              (sram_q),
      .active              (active),
      .reg_scci_enable     (reg_scci_enable),
      .reg_frequency_count (reg_frequency_count),
      .reg_volume          (reg_volume),
      .reg_enable          (reg_enable),
      .reg_wave_reset      (reg_wave_reset),
      .clear_counter_a     (clear_counter_a),
      .clear_counter_b     (clear_counter_b),
      .clear_counter_c     (clear_counter_c),
      .clear_counter_d     (clear_counter_d),
      .clear_counter_e     (clear_counter_e),
      .state_dbg           (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   // Event counters seen by the mixer (one per enable cycle). enable only
   // changes shortly after a rising edge, so its value here is the one the
   // next rising edge will use.
   int we_evt = 0, ack_evt = 0, ack_dis = 0;
   int clr_evt [5] = '{0, 0, 0, 0, 0};
   always @(negedge clk) begin
      if (enable) begin
         if (sram_we)         we_evt++;
         if (bus.bus_ack)     ack_evt++;
         if (clear_counter_a) clr_evt[0]++;
         if (clear_counter_b) clr_evt[1]++;
         if (clear_counter_c) clr_evt[2]++;
         if (clear_counter_d) clr_evt[3]++;
         if (clear_counter_e) clr_evt[4]++;
      end else if (bus.bus_ack) begin
         ack_dis++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full bus transaction with enable held high; returns cycles to ack.
   task automatic bus_op(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] q, output logic qen);
      @(negedge clk);
      bus.bus_req = 1'b1;
      bus.bus_wr  = wr;
      bus.bus_a   = a;
      bus.bus_d   = d;
      lat = 0;
      forever begin
         @(posedge clk); #1;
         lat++;
         if (bus.bus_ack) break;
         if (lat > 20) begin
            check("ack_timeout", 32'(lat), 32'd0);
            break;
         end
      end
      q   = bus.bus_q;
      qen = bus.bus_q_en;
      bus.bus_req = 1'b0;
      @(posedge clk); #1;
   endtask

   int lat;
   logic [7:0] q;
   logic qen;
   int base_we, base_ack, base_dis, base_a, base_other;

   initial begin
      // Reset
      nreset = 1'b0;
      enable = 1'b1;
      bus.bus_req = 1'b0;
      bus.bus_wr  = 1'b0;
      bus.bus_a   = 16'h0000;
      bus.bus_d   = 8'h00;
      sram_q = 8'h77;
      active = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", bus.bus_ready, 1'b1);
      check("rst_ack", bus.bus_ack, 1'b0);
      check("rst_q", bus.bus_q, 8'hFF);
      check("rst_q_en", bus.bus_q_en, 1'b0);
      check("rst_oe_we", {sram_oe, sram_we}, 2'b00);
      check("rst_scci", reg_scci_enable, 1'b0);
      check("rst_state", state_dbg, 2'd0);
      for (int i = 0; i < 8; i++) begin
         active = 3'(i);
         #1;
         check("rst_freq", reg_frequency_count, 12'd0);
      end
      nreset = 1'b1;
      @(posedge clk); #1;

      // Bank select, then wave write timing
      bus_op(1'b1, 16'h9000, 8'h3F, lat, q, qen);
      check("bank9_lat", 32'(lat), 32'd1);
      base_we = we_evt;
      @(negedge clk);
      bus.bus_req = 1'b1; bus.bus_wr = 1'b1; bus.bus_a = 16'h9800; bus.bus_d = 8'h5A;
      @(posedge clk); #1;
      check("wv_issue_we", {sram_oe, sram_we}, 2'b01);
      check("wv_issue_addr", {sram_id, sram_a, sram_d}, {3'd0, 5'd0, 8'h5A});
      check("wv_issue_ack", bus.bus_ack, 1'b0);
      @(posedge clk); #1;
      check("wv_wait_we", sram_we, 1'b0);
      @(posedge clk); #1;
      check("wv_done_ack", bus.bus_ack, 1'b1);
      bus.bus_req = 1'b0;
      @(posedge clk); #1;
      check("wv_we_events", 32'(we_evt - base_we), 32'd1);

      // Frequency writes and clear pulses
      base_a = clr_evt[0];
      base_other = clr_evt[1] + clr_evt[2] + clr_evt[3] + clr_evt[4];
      bus_op(1'b1, 16'h9880, 8'h34, lat, q, qen);
      check("frq_lat", 32'(lat), 32'd1);
      check("clr_a_one", 32'(clr_evt[0] - base_a), 32'd1);
      bus_op(1'b1, 16'h9881, 8'hF2, lat, q, qen);
      active = 3'd0; #1;
      check("freq_a", reg_frequency_count, 12'h234);
      check("clr_a_two", 32'(clr_evt[0] - base_a), 32'd2);
      check("clr_others", 32'(clr_evt[1] + clr_evt[2] + clr_evt[3] + clr_evt[4] - base_other), 32'd0);
      active = 3'd5; #1;
      check("freq_slot5", reg_frequency_count, 12'd0);

      // Volume / enable slot mux
      bus_op(1'b1, 16'h988B, 8'h0F, lat, q, qen);
      bus_op(1'b1, 16'h988F, 8'h02, lat, q, qen);
      active = 3'd2; #1;
      check("vol_slot2", {reg_volume, reg_enable}, {4'hF, 1'b1});
      active = 3'd1; #1;
      check("vol_slot1", {reg_volume, reg_enable}, {4'h0, 1'b0});
      active = 3'd0; #1;
      check("vol_slot0", {reg_volume, reg_enable}, {4'h0, 1'b0});

      // Register read in SCC mode (mirrored offset)
      bus_op(1'b0, 16'h9A80, 8'h00, lat, q, qen);
      check("rdreg", {qen, q}, {1'b1, 8'hFF});

      // SCC-I mode, wave read of channel E
      bus_op(1'b1, 16'hBFFE, 8'h20, lat, q, qen);
      check("scci_on", reg_scci_enable, 1'b1);
      bus_op(1'b1, 16'hB000, 8'h80, lat, q, qen);
      exp_q.push_back(8'h77);
      @(negedge clk);
      bus.bus_req = 1'b1; bus.bus_wr = 1'b0; bus.bus_a = 16'hB880;
      @(posedge clk); #1;
      check("rd_issue", {sram_oe, sram_we, sram_id, sram_a}, {1'b1, 1'b0, 3'd4, 5'd0});
      lat = 1;
      while (!bus.bus_ack && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rd_lat", 32'(lat), 32'd3);
      check("rd_data", bus.bus_q, exp_q.pop_front());
      check("rd_q_en", bus.bus_q_en, 1'b1);
      bus.bus_req = 1'b0;
      @(posedge clk); #1;
      bus_op(1'b0, 16'h9800, 8'h00, lat, q, qen);
      check("scc_miss", {qen, q}, {1'b0, 8'hFF});

      // Back to SCC mode; deformation write with enable toggling
      bus_op(1'b1, 16'hBFFE, 8'h00, lat, q, qen);
      check("scci_off", reg_scci_enable, 1'b0);
      base_ack = ack_evt;
      base_dis = ack_dis;
      @(negedge clk);
      bus.bus_req = 1'b1; bus.bus_wr = 1'b1; bus.bus_a = 16'h98C0; bus.bus_d = 8'h20;
      @(posedge clk); #1;
      check("en_ack1", bus.bus_ack, 1'b1);
      bus.bus_req = 1'b0;
      #2 enable = 1'b0;
      @(posedge clk); #1;
      check("en_ack_hold", bus.bus_ack, 1'b1);
      #2 enable = 1'b1;
      @(posedge clk); #1;
      check("en_ack_drop", bus.bus_ack, 1'b0);
      check("wave_reset", reg_wave_reset, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("en_ack_events", 32'(ack_evt - base_ack), 32'd1);
      check("en_ack_disabled", 32'(ack_dis - base_dis), 32'd1);

      // Reset in the middle of a wave access aborts without ack
      @(negedge clk);
      bus.bus_req = 1'b1; bus.bus_wr = 1'b0; bus.bus_a = 16'h9810;
      @(posedge clk); #1;
      check("abort_issue", state_dbg, 2'd1);
      nreset = 1'b0;
      bus.bus_req = 1'b0;
      @(posedge clk); #1;
      check("abort_state", {state_dbg, bus.bus_ack, sram_oe}, {2'd0, 1'b0, 1'b0});
      check("abort_regs", {reg_wave_reset, bus.bus_q}, {1'b0, 8'hFF});
      nreset = 1'b1;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
